// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared types and default timing for the DRAM controller
// refresh path. Holds the command encoding seen by the issue stage, the
// refresh scheduler state type and the default precharge/refresh waits.
package dram_ctrl_pkg;

   // Command presented to the issue stage by the refresh path.
   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_PREA = 2'b01,
      CMD_REF  = 2'b10
   } cmd_type_t;

   // Refresh scheduler sequencing states.
   typedef enum logic [2:0] {
      IDLE,
      HOST,
      PREA,
      WAIT_RP,
      REF,
      WAIT_RFC
   } sched_state_t;

   // Default timing, in clk cycles.
   localparam int DEF_T_RP  = 3;   // precharge-all to REF
   localparam int DEF_T_RFC = 26;  // REF to next command

   // Width of a down-counter that must hold (longest wait - 1).
   function automatic int timer_width(input int t_rp, input int t_rfc);
      int longest;
      longest = (t_rp > t_rfc) ? t_rp : t_rfc;
      return (longest > 1) ? $clog2(longest) : 1;
   endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// refresh_scheduler_if: command-bus sharing signals between the refresh
// scheduler, the host port and the command issue stage.
//   master : the scheduler (grants the host, presents refresh commands)
//   slave  : the surrounding controller (host requests, issue-stage ready)
interface refresh_scheduler_if;
   import dram_ctrl_pkg::*;

   logic      host_req;   // host wants the command bus
   logic      host_done;  // host burst finished (pulse while host_gnt=1)
   logic      host_gnt;   // host owns the command bus
   logic      cmd_valid;  // refresh-path command valid
   cmd_type_t cmd_type;   // refresh-path command
   logic      cmd_ready;  // issue stage accepts the command

   modport master (
      input  host_req, host_done, cmd_ready,
      output host_gnt, cmd_valid, cmd_type
   );

   modport slave (
      output host_req, host_done, cmd_ready,
      input  host_gnt, cmd_valid, cmd_type
   );

endinterface

// File: rtl/ref_debt_counter.sv
// ref_debt_counter: outstanding-refresh bookkeeping. Counts refresh ticks up
// and REF handshakes down, saturates at MAX_POSTPONE, flags a lost refresh
// with a sticky overflow bit and reports urgency from the registered count.
module ref_debt_counter #(
   parameter int MAX_POSTPONE = 8,
   parameter int URGENT_TH    = 6,
   parameter int DEBT_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,       // refresh tick
   input  logic              dec,       // REF handshake
   output logic [DEBT_W-1:0] debt,
   output logic              urgent,
   output logic              overflow
);

   localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_POSTPONE);
   localparam logic [DEBT_W-1:0] DEBT_URG = DEBT_W'(URGENT_TH);
   localparam logic [DEBT_W-1:0] ONE      = DEBT_W'(1);

   // Saturating up/down debt count with sticky overflow. A tick that coincides
   // with a REF handshake cancels out, so no refresh is lost even at the limit.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!rst) begin
         debt     <= '0;
         overflow <= 1'b0;
      end else if (inc && !dec) begin
         if (debt == DEBT_MAX) overflow <= 1'b1;
         else                  debt     <= debt + ONE;
      end else if (dec && !inc && (debt != '0)) begin
         debt <= debt - ONE;
      end
   end

   assign urgent = (debt >= DEBT_URG);

endmodule

// File: rtl/refresh_scheduler.sv
// refresh_scheduler: sequences DRAM auto-refresh (precharge-all, then one or
// more batched REFs) and shares the command bus with host bursts. Host bursts
// are never preempted; a high refresh debt stops new host grants instead.
// Optional build macro REF_SCHED_STATS_EN adds a 16-bit REF issue counter and
// a debt watermark; without it those ports are tied to zero.
module refresh_scheduler
   import dram_ctrl_pkg::*;
#(
   parameter int MAX_POSTPONE = 8,
   parameter int URGENT_TH    = 6,
   parameter int T_RP         = DEF_T_RP,
   parameter int T_RFC        = DEF_T_RFC,
   parameter int DEBT_W       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sched_en,
   input  logic                refresh_tick,
   refresh_scheduler_if.master bus,
   output logic [DEBT_W-1:0]   ref_debt,
   output logic                ref_urgent,
   output logic                ref_overflow,
   output logic [15:0]         ref_issued_cnt,
   output logic [DEBT_W-1:0]   ref_debt_max
);

   localparam int TW = timer_width(T_RP, T_RFC);

   sched_state_t  state, state_next;
   logic [TW-1:0] timer, timer_next;
   logic          host_gnt_c;
   logic          cmd_valid_c;
   cmd_type_t     cmd_type_c;
   logic          ref_hs;
   logic          debt_nz;
   logic          seq_start;
   logic          seq_more;

   assign ref_hs  = (state == REF) && bus.cmd_ready;
   assign debt_nz = (ref_debt != '0);

   // Start a sequence from IDLE: always when urgent, otherwise only when the
   // host is not asking for the bus.
   assign seq_start = sched_en && (ref_urgent || (debt_nz && !bus.host_req));

   // After tRFC, batch another REF without a new precharge-all.
   assign seq_more = debt_nz && sched_en && (ref_urgent || !bus.host_req);

   ref_debt_counter #(
      .MAX_POSTPONE (MAX_POSTPONE),
      .URGENT_TH    (URGENT_TH),
      .DEBT_W       (DEBT_W)
   ) u_debt (
      .clk      (clk),
      .rst      (rst),
      .inc      (refresh_tick),
      .dec      (ref_hs),
      .debt     (ref_debt),
      .urgent   (ref_urgent),
      .overflow (ref_overflow)
   );

   // State and wait-timer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   // Next-state logic and Moore outputs; outputs depend on state only, so an
   // asynchronous reset clears them immediately.
   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_next  = state;
      timer_next  = timer;
      host_gnt_c  = 1'b0;
      cmd_valid_c = 1'b0;
      cmd_type_c  = CMD_NOP;

      unique case (state)
         IDLE: begin
            if (seq_start)         state_next = PREA;
            else if (bus.host_req) state_next = HOST;
         end

         HOST: begin
            host_gnt_c = 1'b1;
            if (bus.host_done) state_next = IDLE;
         end

         PREA: begin
            cmd_valid_c = 1'b1;
            cmd_type_c  = CMD_PREA;
            if (bus.cmd_ready) begin
               state_next = WAIT_RP;
               timer_next = TW'(T_RP - 1);
            end
         end

         WAIT_RP: begin
            if (timer == '0) state_next = REF;
            else             timer_next = timer - TW'(1);
         end

         REF: begin
            cmd_valid_c = 1'b1;
            cmd_type_c  = CMD_REF;
            if (bus.cmd_ready) begin
               state_next = WAIT_RFC;
               timer_next = TW'(T_RFC - 1);
            end
         end

         WAIT_RFC: begin
            if (timer == '0) state_next = seq_more ? REF : IDLE;
            else             timer_next = timer - TW'(1);
         end

         default: state_next = IDLE;
      endcase
   end

   assign bus.host_gnt  = host_gnt_c;
   assign bus.cmd_valid = cmd_valid_c;
   assign bus.cmd_type  = cmd_type_c;

`ifdef REF_SCHED_STATS_EN
   // REF issue counter (wraps) and highest debt seen since reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_issued_cnt <= '0;
         ref_debt_max   <= '0;
      end else begin
         if (ref_hs)                  ref_issued_cnt <= ref_issued_cnt + 16'd1;
         if (ref_debt > ref_debt_max) ref_debt_max   <= ref_debt;
      end
   end
`else
   assign ref_issued_cnt = '0;
   assign ref_debt_max   = '0;
`endif

endmodule

// File: tb/tb_refresh_scheduler.sv
// tb_refresh_scheduler: directed scenarios plus randomized traffic for the
// refresh scheduler, compared every cycle against a behavioural model of the
// bus-sharing rules, with literal expectations on key latencies.
module tb_refresh_scheduler;

   localparam int MAXP = 8;
   localparam int UTH  = 6;
   localparam int TRP  = 3;
   localparam int TRFC = 26;
   localparam int DW   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          sched_en;
   logic          refresh_tick;
   logic [DW-1:0] ref_debt;
   logic          ref_urgent;
   logic          ref_overflow;
   logic [15:0]   ref_issued_cnt;
   logic [DW-1:0] ref_debt_max;

   int n_checks = 0;
   int n_errors = 0;

   refresh_scheduler_if bus ();

   refresh_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .sched_en       (sched_en),
      .refresh_tick   (refresh_tick),
      .bus            (bus),
      .ref_debt       (ref_debt),
      .ref_urgent     (ref_urgent),
      .ref_overflow   (ref_overflow),
      .ref_issued_cnt (ref_issued_cnt),
      .ref_debt_max   (ref_debt_max)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model. The refresh path is described as "which command is
   // being offered" plus "cycles left in the current quiet gap" and what that
   // gap leads to; the host path is a single ownership flag.
   // ---------------------------------------------------------------------
   int          m_debt;      // outstanding refreshes
   bit          m_ovf;       // a refresh was lost
   bit          m_gnt;       // host owns the bus
   int          m_cmd;       // 0 none offered, 1 PREA offered, 2 REF offered
   int          m_gap;       // quiet cycles left after an accepted command
   bit          m_gap_ref;   // gap ends in a mandatory REF (after PREA)
   logic [15:0] m_issued;
   int          m_max;
   bit          m_hs;
   bit          m_urg;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_debt = 0; m_ovf = 0; m_gnt = 0; m_cmd = 0; m_gap = 0;
         m_gap_ref = 0; m_issued = 0; m_max = 0;
      end else begin
         m_hs  = (m_cmd == 2) && bus.cmd_ready;
         m_urg = (m_debt >= UTH);
         if (m_gnt) begin
            if (bus.host_done) m_gnt = 0;
         end else if (m_cmd != 0) begin
            if (bus.cmd_ready) begin
               m_gap_ref = (m_cmd == 1);
               m_gap     = m_gap_ref ? TRP : TRFC;
               m_cmd     = 0;
            end
         end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
               if (m_gap_ref) m_cmd = 2;
               else if (m_debt > 0 && sched_en && (m_urg || !bus.host_req)) m_cmd = 2;
            end
         end else begin
            if (sched_en && (m_urg || (m_debt > 0 && !bus.host_req))) m_cmd = 1;
            else if (bus.host_req) m_gnt = 1;
         end
         if (m_debt > m_max) m_max = m_debt;
         if (m_hs) m_issued++;
         if (refresh_tick && !m_hs) begin
            if (m_debt == MAXP) m_ovf = 1;
            else m_debt++;
         end else if (m_hs && !refresh_tick && m_debt > 0) begin
            m_debt--;
         end
      end
   end

   // Compare process: outputs are Moore/registered, checked mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         check("cmp host_gnt",  bus.host_gnt,  m_gnt);
         check("cmp cmd_valid", bus.cmd_valid, m_cmd != 0);
         check("cmp cmd_type",  bus.cmd_type,  m_cmd);
         check("cmp ref_debt",  ref_debt,      m_debt);
         check("cmp urgent",    ref_urgent,    m_debt >= UTH);
         check("cmp overflow",  ref_overflow,  m_ovf);
         check("cmp exclusive", bus.host_gnt && bus.cmd_valid, 0);
`ifdef REF_SCHED_STATS_EN
         check("cmp issued_cnt", ref_issued_cnt, m_issued);
         check("cmp debt_max",   ref_debt_max,   m_max);
`else
         check("cmp issued_cnt", ref_issued_cnt, 0);
         check("cmp debt_max",   ref_debt_max,   0);
`endif
      end
   end

   // Bounded waits. n counts negedges until the condition is first seen.
   task automatic wait_cmd(input int t, input string nm, output int n);
      bit seen;
      n = 0;
      seen = 0;
      while (!seen && n < 600) begin
         @(negedge clk);
         n++;
         seen = bus.cmd_valid && (bus.cmd_type == t);
      end
      check({nm, " seen"}, seen, 1);
   endtask

   task automatic wait_gnt(input string nm, output int n);
      n = 0;
      while (!bus.host_gnt && n < 600) begin
         @(negedge clk);
         n++;
      end
      check({nm, " seen"}, bus.host_gnt, 1);
   endtask

   task automatic wait_debt0(input string nm);
      int n;
      n = 0;
      while (ref_debt != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({nm, " drained"}, ref_debt, 0);
   endtask

   task automatic host_release();
      bus.host_done = 1'b1;
      bus.host_req  = 1'b0;
      @(negedge clk);
      bus.host_done = 1'b0;
   endtask

   // Watchdog: the bench must always end.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1);
   end

   initial begin
      int n;
      int rate;

      bus.host_req  = 1'b0;
      bus.host_done = 1'b0;
      bus.cmd_ready = 1'b1;
      sched_en      = 1'b1;
      refresh_tick  = 1'b0;
      rst           = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("reset gnt",   bus.host_gnt,  0);
      check("reset valid", bus.cmd_valid, 0);
      check("reset debt",  ref_debt,      0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Idle single refresh.
      @(negedge clk);
      refresh_tick = 1'b1;
      @(negedge clk);
      refresh_tick = 1'b0;
      check("single debt after tick", ref_debt, 1);
      check("single model debt", m_debt, 1);
      check("single no cmd yet", bus.cmd_valid, 0);
      @(negedge clk);
      check("single prea valid", bus.cmd_valid, 1);
      check("single prea type", bus.cmd_type, 1);
      wait_cmd(2, "single ref", n);
      check("single prea->ref cycles", n, TRP + 1);
      @(negedge clk);
      check("single debt drained", ref_debt, 0);
      bus.host_req = 1'b1;
      wait_gnt("single regrant", n);
      check("single ref->idle->host cycles", n, TRFC + 1);
      host_release();
      check("single host released", bus.host_gnt, 0);

      // Backpressure in PREA.
      bus.cmd_ready = 1'b0;
      refresh_tick  = 1'b1;
      @(negedge clk);
      refresh_tick  = 1'b0;
      wait_cmd(1, "bp prea", n);
      check("bp prea latency", n, 1);
      for (int i = 2; i <= 6; i++) begin
         @(negedge clk);
         check("bp hold valid", bus.cmd_valid, 1);
         check("bp hold type", bus.cmd_type, 1);
         check("bp no gnt", bus.host_gnt, 0);
      end
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      check("bp handshake taken", bus.cmd_valid, 0);
      wait_cmd(2, "bp ref", n);
      check("bp wait_rp cycles", n, TRP);
      repeat (TRFC + 3) @(negedge clk);

      // Tick coincident with a REF handshake at debt 2.
      sched_en     = 1'b0;
      refresh_tick = 1'b1;
      repeat (2) @(negedge clk);
      refresh_tick = 1'b0;
      check("coinc debt before", ref_debt, 2);
      bus.cmd_ready = 1'b0;
      sched_en      = 1'b1;
      wait_cmd(1, "coinc prea", n);
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      wait_cmd(2, "coinc ref", n);
      bus.cmd_ready = 1'b1;
      refresh_tick  = 1'b1;
      @(negedge clk);
      refresh_tick  = 1'b0;
      check("coinc debt unchanged", ref_debt, 2);
      check("coinc model debt", m_debt, 2);
      wait_debt0("coinc");
      repeat (TRFC + 3) @(negedge clk);

      // Urgency during a long host burst.
      bus.host_req = 1'b1;
      wait_gnt("urg grant", n);
      refresh_tick = 1'b1;
      repeat (6) @(negedge clk);
      refresh_tick = 1'b0;
      check("urg flag", ref_urgent, 1);
      check("urg debt", ref_debt, 6);
      check("urg burst kept", bus.host_gnt, 1);
      bus.host_done = 1'b1;
      @(negedge clk);
      bus.host_done = 1'b0;
      check("urg host ended", bus.host_gnt, 0);
      @(negedge clk);
      check("urg refresh wins", bus.cmd_valid && bus.cmd_type == 1, 1);
      check("urg no regrant", bus.host_gnt, 0);
      bus.host_req = 1'b0;
      wait_cmd(2, "urg first ref", n);
      check("urg prea->ref", n, TRP + 1);
      for (int i = 0; i < 5; i++) begin
         wait_cmd(2, "urg batched ref", n);
         check("urg ref spacing", n, TRFC + 1);
      end
      @(negedge clk);
      check("urg debt drained", ref_debt, 0);
      bus.host_req = 1'b1;
      wait_gnt("urg host back", n);
      host_release();

      // Saturation and sticky overflow.
      sched_en     = 1'b0;
      refresh_tick = 1'b1;
      repeat (9) @(negedge clk);
      refresh_tick = 1'b0;
      check("sat debt", ref_debt, MAXP);
      check("sat overflow", ref_overflow, 1);
      check("sat model overflow", m_ovf, 1);
      sched_en = 1'b1;
      wait_debt0("sat");
      check("sat overflow sticky", ref_overflow, 1);
      repeat (TRFC + 3) @(negedge clk);

      // Asynchronous reset in the middle of WAIT_RFC with debt 3.
      sched_en     = 1'b0;
      refresh_tick = 1'b1;
      repeat (4) @(negedge clk);
      refresh_tick = 1'b0;
      sched_en     = 1'b1;
      wait_cmd(2, "rst ref", n);
      @(negedge clk);
      check("rst debt before", ref_debt, 3);
      #2 rst = 1'b0;
      #1;
      check("rst async valid", bus.cmd_valid, 0);
      check("rst async type", bus.cmd_type, 0);
      check("rst async gnt", bus.host_gnt, 0);
      check("rst async debt", ref_debt, 0);
      check("rst async urgent", ref_urgent, 0);
      check("rst async overflow", ref_overflow, 0);
      @(negedge clk);
      rst          = 1'b1;
      bus.host_req = 1'b1;
      @(negedge clk);
      check("rst idle then host", bus.host_gnt, 1);
      host_release();

      // Randomized traffic against the model.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         rate = ((cyc / 500) % 2 == 1) ? 3 : 25;
         refresh_tick  = ($urandom_range(rate - 1) == 0);
         sched_en      = ($urandom_range(15) != 0);
         bus.cmd_ready = ($urandom_range(3) != 0);
         if ($urandom_range(7) == 0) bus.host_req = ~bus.host_req;
         bus.host_done = m_gnt && ($urandom_range(5) == 0);
      end
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
